// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bus shared by the producers, the packet arbiter and the L_FIFO write port.
// The master side drives requests and FIFO flags; the slave side is the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_wr_data;
    logic                          fifo_wr_full;
    logic                          fifo_almost_full;

    modport master (
        output req_valid,
        output req_data,
        output req_last,
        output fifo_wr_full,
        output fifo_almost_full,
        input  req_ready,
        input  fifo_wr_en,
        input  fifo_wr_data
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_last,
        input  fifo_wr_full,
        input  fifo_almost_full,
        output req_ready,
        output fifo_wr_en,
        output fifo_wr_data
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Packet-level round-robin arbiter sharing one L_FIFO write port among NUM_REQ producers.
// A grant lasts for a whole packet; new grants are withheld while the FIFO is almost full.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 tb_rst,
    fifo_wr_arbiter_if.slave     bus,
    output logic                 busy,
    output logic [ID_WIDTH-1:0]  grant_id,
    output logic                 pkt_done,
    output logic [CNT_WIDTH-1:0] beat_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ID_WIDTH-1:0]   rr_ptr;
    logic [ID_WIDTH-1:0]   rr_ptr_nxt;
    logic [ID_WIDTH-1:0]   grant_nxt;
    logic [ID_WIDTH-1:0]   grant_succ;
    logic [ID_WIDTH-1:0]   winner;
    logic                  win_found;
    logic                  pkt_done_nxt;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [NUM_REQ-1:0]    ready_vec;
    logic                  last_write;

    // Two-pass search: requesters at or above the pointer first, then the wrapped-around ones.
    always_comb begin
        winner    = '0;
        win_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && bus.req_valid[i] && (ID_WIDTH'(i) >= rr_ptr)) begin
                winner    = ID_WIDTH'(i);
                win_found = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && bus.req_valid[i]) begin
                winner    = ID_WIDTH'(i);
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_WIDTH'(i)) begin
                sel_valid = bus.req_valid[i];
                sel_last  = bus.req_last[i];
                sel_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign busy = (state == BUSY);

    // Ready is offered to the granted requester regardless of its valid, so a stalled producer sees it.
    always_comb begin
        ready_vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ready_vec[i] = busy && !bus.fifo_wr_full && (grant_id == ID_WIDTH'(i));
        end
    end

    assign bus.req_ready    = ready_vec;
    assign bus.fifo_wr_en   = busy & sel_valid & ~bus.fifo_wr_full;
    assign bus.fifo_wr_data = busy ? sel_data : '0;
    assign last_write       = bus.fifo_wr_en & sel_last;
    assign grant_succ       = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant_id;
        rr_ptr_nxt   = rr_ptr;
        pkt_done_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.fifo_almost_full && win_found) begin
                    state_nxt = BUSY;
                    grant_nxt = winner;
                end
            end
            BUSY: begin
                if (last_write) begin
                    state_nxt    = IDLE;
                    rr_ptr_nxt   = grant_succ;
                    pkt_done_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            grant_id <= '0;
            rr_ptr   <= '0;
            pkt_done <= 1'b0;
        end else begin
            grant_id <= grant_nxt;
            rr_ptr   <= rr_ptr_nxt;
            pkt_done <= pkt_done_nxt;
        end
    end

    // Saturating count of every beat written into the FIFO.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            beat_cnt <= '0;
        end else if (bus.fifo_wr_en && (beat_cnt != '1)) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized traffic
// checked by a scoreboard fed from a packet-level round-robin reference model.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ    = 3;
    localparam int DATA_WIDTH = 8;
    localparam int ID_WIDTH   = 2;
    localparam int CNT_WIDTH  = 6;
    localparam int SAT_VALUE  = (1 << CNT_WIDTH) - 1;
    localparam int MAX_BEATS  = 256;
    localparam int MAX_PKTS   = 64;

    typedef struct packed {
        logic [1:0] req;
        logic       last;
        logic [7:0] data;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 tb_rst = 1'b1;
    logic                 busy;
    logic [ID_WIDTH-1:0]  grant_id;
    logic                 pkt_done;
    logic [CNT_WIDTH-1:0] beat_cnt;

    fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_WIDTH(DATA_WIDTH),
        .ID_WIDTH  (ID_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk     (clk),
        .tb_rst  (tb_rst),
        .bus     (bus),
        .busy    (busy),
        .grant_id(grant_id),
        .pkt_done(pkt_done),
        .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    exp_t exp_q[$];
    int   grant_log[$];
    bit   mon_en = 1'b0;
    bit   seen_wr = 1'b0;
    int   first_wr_cyc = 0;
    int   last_wr_cyc = 0;

    // Producer storage: each entry is {first, last, data}.
    logic [9:0]         src_mem [NUM_REQ][MAX_BEATS];
    int                 src_len [NUM_REQ];
    int                 src_pos [NUM_REQ];
    int                 pkt_start [NUM_REQ][MAX_PKTS];
    int                 pkt_len [NUM_REQ][MAX_PKTS];
    int                 pkt_cnt [NUM_REQ];
    logic [NUM_REQ-1:0] hs;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Scoreboard monitor: every FIFO write must match the head of the expected stream.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en && !tb_rst && (bus.fifo_wr_en === 1'b1)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL sb_unexpected_write actual=0x%0h expected=no_write", bus.fifo_wr_data);
            end else begin
                e = exp_q.pop_front();
                checkOutput("sb_data", 32'(bus.fifo_wr_data), 32'(e.data));
                checkOutput("sb_grant", 32'(grant_id), 32'(e.req));
                if (e.last) grant_log.push_back(int'(grant_id));
                if (!seen_wr) first_wr_cyc = cyc;
                seen_wr     = 1'b1;
                last_wr_cyc = cyc;
            end
        end
    end

    task automatic setReq(input int r, input logic v, input logic [7:0] d, input logic l);
        bus.req_valid[r] = v;
        bus.req_data[r*DATA_WIDTH +: DATA_WIDTH] = d;
        bus.req_last[r] = l;
    endtask

    task automatic clearInputs();
        bus.req_valid        = '0;
        bus.req_data         = '0;
        bus.req_last         = '0;
        bus.fifo_wr_full     = 1'b0;
        bus.fifo_almost_full = 1'b0;
    endtask

    task automatic applyReset();
        clearInputs();
        tb_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 tb_rst = 1'b0;
    endtask

    // Builds producer packets and the expected write stream from packet-level round robin.
    task automatic genTraffic(input int npk, input int minlen, input int maxlen, input logic [NUM_REQ-1:0] mask);
        int   nxt [NUM_REQ];
        int   mptr;
        int   r;
        int   len;
        bit   found;
        exp_t e;
        logic [9:0] w;
        exp_q.delete();
        grant_log.delete();
        seen_wr = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
            pkt_cnt[i] = 0;
            nxt[i]     = 0;
            if (mask[i]) begin
                for (int p = 0; p < npk; p++) begin
                    len = $urandom_range(maxlen, minlen);
                    pkt_start[i][p] = src_len[i];
                    pkt_len[i][p]   = len;
                    for (int b = 0; b < len; b++) begin
                        src_mem[i][src_len[i]] = {b == 0, b == len - 1, 8'($urandom)};
                        src_len[i]++;
                    end
                    pkt_cnt[i]++;
                end
            end
        end
        mptr = 0;
        do begin
            found = 1'b0;
            for (int k = 0; k < NUM_REQ; k++) begin
                r = (mptr + k) % NUM_REQ;
                if (!found && nxt[r] < pkt_cnt[r]) begin
                    for (int b = 0; b < pkt_len[r][nxt[r]]; b++) begin
                        w      = src_mem[r][pkt_start[r][nxt[r]] + b];
                        e.req  = 2'(r);
                        e.last = w[8];
                        e.data = w[7:0];
                        exp_q.push_back(e);
                    end
                    nxt[r]++;
                    mptr  = (r + 1) % NUM_REQ;
                    found = 1'b1;
                end
            end
        end while (found);
    endtask

    task automatic applyStimulus(input bit rand_full, input bit rand_af, input bit rand_bubble);
        for (int i = 0; i < NUM_REQ; i++) begin
            logic [9:0] w;
            bit         bubble;
            if (src_pos[i] < src_len[i]) begin
                w      = src_mem[i][src_pos[i]];
                bubble = rand_bubble && !w[9] && ($urandom_range(3) == 0);
                setReq(i, !bubble, w[7:0], w[8]);
            end else begin
                setReq(i, 1'b0, 8'h00, 1'b0);
            end
        end
        bus.fifo_wr_full     = rand_full && ($urandom_range(3) == 0);
        bus.fifo_almost_full = rand_af && ($urandom_range(9) < 3);
    endtask

    task automatic runTraffic(input int max_cycles, input bit rand_full, input bit rand_af, input bit rand_bubble);
        int n = 0;
        bit done = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1 applyStimulus(rand_full, rand_af, rand_bubble);
        while (!done && n < max_cycles) begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) hs[i] = bus.req_valid[i] & bus.req_ready[i];
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) if (hs[i]) src_pos[i]++;
            applyStimulus(rand_full, rand_af, rand_bubble);
            done = 1'b1;
            for (int i = 0; i < NUM_REQ; i++) if (src_pos[i] < src_len[i]) done = 1'b0;
            n++;
        end
        clearInputs();
        if (!done) begin
            checks++;
            failures++;
            $display("[TB] FAIL traffic_timeout actual=%0d_cycles expected=completion", n);
        end
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("idle_after_traffic", 32'(busy), 32'd0);
    endtask

    // One packet from requester r with all others idle; optional full stall before beat stall_beat.
    task automatic sendDirect(input int r, input logic [7:0] base, input int len,
                              input int stall_beat, input int stall_cycles);
        @(posedge clk);
        #1 setReq(r, 1'b1, base, len == 1);
        @(negedge clk);
        checkOutput("arb_cycle_busy", 32'(busy), 32'd0);
        checkOutput("arb_cycle_wren", 32'(bus.fifo_wr_en), 32'd0);
        for (int b = 0; b < len; b++) begin
            @(posedge clk);
            #1 setReq(r, 1'b1, base + 8'(b), b == len - 1);
            if (b == stall_beat) begin
                bus.fifo_wr_full = 1'b1;
                repeat (stall_cycles) begin
                    @(negedge clk);
                    checkOutput("stall_ready", 32'(bus.req_ready), 32'd0);
                    checkOutput("stall_wren", 32'(bus.fifo_wr_en), 32'd0);
                    checkOutput("stall_grant", 32'(grant_id), 32'(r));
                    @(posedge clk);
                    #1;
                end
                bus.fifo_wr_full = 1'b0;
            end
            @(negedge clk);
            checkOutput("beat_wren", 32'(bus.fifo_wr_en), 32'd1);
            checkOutput("beat_data", 32'(bus.fifo_wr_data), 32'(base + 8'(b)));
            checkOutput("beat_ready", 32'(bus.req_ready), 32'(1 << r));
            checkOutput("beat_grant", 32'(grant_id), 32'(r));
        end
        @(posedge clk);
        #1 setReq(r, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        checkOutput("pkt_end_busy", 32'(busy), 32'd0);
        checkOutput("pkt_done_pulse", 32'(pkt_done), 32'd1);
    endtask

    initial begin
        int total;
        logic [NUM_REQ-1:0] mask;

        clearInputs();
        tb_rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_grant", 32'(grant_id), 32'd0);
        checkOutput("rst_pkt_done", 32'(pkt_done), 32'd0);
        checkOutput("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        checkOutput("rst_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("rst_wren", 32'(bus.fifo_wr_en), 32'd0);
        checkOutput("rst_wrdata", 32'(bus.fifo_wr_data), 32'd0);
        setReq(1, 1'b1, 8'h77, 1'b1);
        @(negedge clk);
        checkOutput("rst_holds_idle", 32'(busy), 32'd0);
        clearInputs();
        @(posedge clk);
        #1 tb_rst = 1'b0;

        $display("[TB] 4-beat packet from requester 0");
        sendDirect(0, 8'h10, 4, -1, 0);
        @(negedge clk);
        checkOutput("pkt_done_one_cycle", 32'(pkt_done), 32'd0);
        checkOutput("beat_cnt_4", 32'(beat_cnt), 32'd4);

        $display("[TB] single-beat packet from requester 2");
        sendDirect(2, 8'hA5, 1, -1, 0);
        checkOutput("beat_cnt_5", 32'(beat_cnt), 32'd5);
        @(posedge clk);
        #1;
        setReq(0, 1'b1, 8'h30, 1'b1);
        setReq(1, 1'b1, 8'h31, 1'b1);
        setReq(2, 1'b1, 8'h32, 1'b1);
        @(negedge clk);
        checkOutput("contend_arb_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("contend_grant", 32'(grant_id), 32'd0);
        checkOutput("contend_data", 32'(bus.fifo_wr_data), 32'h30);
        checkOutput("contend_ready", 32'(bus.req_ready), 32'b001);
        @(posedge clk);
        #1 clearInputs();

        $display("[TB] full stall during beat 2");
        sendDirect(0, 8'h20, 4, 1, 5);
        checkOutput("beat_cnt_10", 32'(beat_cnt), 32'd10);

        $display("[TB] almost-full holds off arbitration");
        @(posedge clk);
        #1;
        bus.fifo_almost_full = 1'b1;
        setReq(1, 1'b1, 8'h44, 1'b1);
        repeat (4) begin
            @(negedge clk);
            checkOutput("af_hold_busy", 32'(busy), 32'd0);
        end
        @(posedge clk);
        #1 bus.fifo_almost_full = 1'b0;
        @(negedge clk);
        checkOutput("af_release_arb", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("af_grant_busy", 32'(busy), 32'd1);
        checkOutput("af_grant_id", 32'(grant_id), 32'd1);
        checkOutput("af_grant_data", 32'(bus.fifo_wr_data), 32'h44);
        @(posedge clk);
        #1 clearInputs();

        $display("[TB] asynchronous reset mid-packet");
        @(posedge clk);
        #1 setReq(0, 1'b1, 8'h50, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("mid_beat0", 32'(bus.fifo_wr_data), 32'h50);
        @(posedge clk);
        #1 setReq(0, 1'b1, 8'h51, 1'b0);
        #2;
        checkOutput("mid_beat1_wren", 32'(bus.fifo_wr_en), 32'd1);
        tb_rst = 1'b1;
        #1;
        checkOutput("async_rst_busy", 32'(busy), 32'd0);
        checkOutput("async_rst_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("async_rst_wren", 32'(bus.fifo_wr_en), 32'd0);
        checkOutput("async_rst_cnt", 32'(beat_cnt), 32'd0);
        setReq(0, 1'b1, 8'h60, 1'b1);
        setReq(2, 1'b1, 8'h62, 1'b1);
        @(posedge clk);
        #1 tb_rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_arb", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("post_rst_grant", 32'(grant_id), 32'd0);
        checkOutput("post_rst_data", 32'(bus.fifo_wr_data), 32'h60);
        @(posedge clk);
        #1 clearInputs();

        $display("[TB] two continuous requesters, 3-beat packets");
        applyReset();
        genTraffic(2, 3, 3, 3'b011);
        runTraffic(200, 1'b0, 1'b0, 1'b0);
        checkOutput("rr_pkt_count", 32'(grant_log.size()), 32'd4);
        if (grant_log.size() == 4) begin
            checkOutput("rr_order_0", 32'(grant_log[0]), 32'd0);
            checkOutput("rr_order_1", 32'(grant_log[1]), 32'd1);
            checkOutput("rr_order_2", 32'(grant_log[2]), 32'd0);
            checkOutput("rr_order_3", 32'(grant_log[3]), 32'd1);
        end
        checkOutput("rr_span_cycles", 32'(last_wr_cyc - first_wr_cyc), 32'd14);
        checkOutput("rr_beat_cnt", 32'(beat_cnt), 32'd12);

        $display("[TB] randomized traffic");
        for (int it = 0; it < 3; it++) begin
            applyReset();
            mask = NUM_REQ'($urandom_range(7, 1));
            genTraffic(4, 1, 4, mask);
            total = 0;
            for (int i = 0; i < NUM_REQ; i++) total += src_len[i];
            runTraffic(2000, 1'b1, 1'b1, 1'b1);
            checkOutput("rand_beat_cnt", 32'(beat_cnt), 32'(total));
        end

        $display("[TB] beat counter saturation");
        applyReset();
        genTraffic(8, 4, 6, 3'b111);
        runTraffic(3000, 1'b1, 1'b1, 1'b1);
        checkOutput("sat_beat_cnt", 32'(beat_cnt), 32'(SAT_VALUE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
